// File: rtl/blink_sched.sv
// blink_sched -- shares one board LED between N_REQ requesters.
//
// Each requester asks (level req_i) for a burst of cnt flashes. The LED is
// granted round-robin; a burst is cnt ON/OFF pairs of one tick each,
// followed by GAP_TICKS dark ticks. A tick is one prescaler period of
// DIV = FREQ/TICK_HZ clock cycles. Bursts are not pre-emptible.
//
// Build option: define FIXED_PRIO_EN for fixed priority arbitration
// (lowest index wins, no rotation pointer). Default is round-robin.
//
// Ports:
//   clk_i   system clock
//   rst_i   synchronous reset, active-high
//   req_i   per-requester burst request (level)
//   cnt_i   flash count per requester, field k = cnt_i[k*CNT_W +: CNT_W]
//   gnt_o   one-hot grant, high for the whole burst
//   done_o  one-cycle pulse to the granted requester at burst end
//   busy_o  high whenever the sequencer is not idle
//   led_o   LED drive
module blink_sched #(
  parameter int unsigned FREQ      = 25000000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CNT_W-1:0] cnt_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic                   led_o
);

  localparam int unsigned DIV   = (TICK_HZ > 0) ? FREQ / TICK_HZ : 0;
  localparam int unsigned PC_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DIV - 1);
  localparam logic [PC_W-1:0]  PC_PRE   = PC_W'(DIV - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Elaboration-time parameter checks.
  if (FREQ == 0 || TICK_HZ == 0 || DIV < 2) begin : g_bad_div
    $fatal(1, "blink_sched: FREQ/TICK_HZ must be nonzero and give a divider of at least 2");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $fatal(1, "blink_sched: N_REQ must be in the range 2..8");
  end
  if (GAP_TICKS < 1) begin : g_bad_gap
    $fatal(1, "blink_sched: GAP_TICKS must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cntw
    $fatal(1, "blink_sched: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] rem;
  logic [GAP_W-1:0] gap;
  logic             tick;
  logic             pre_tick;

  logic [PTR_W-1:0] win;
  logic             win_vld;
  logic [N_REQ-1:0] win_oh;
  logic [CNT_W-1:0] cnt_sel;

  // pre_tick is the cycle before the tick; done_o/gnt_o are registered off
  // it so the done pulse lands in the final tick cycle of the gap.
  assign tick     = (pc == PC_LAST);
  assign pre_tick = (pc == PC_PRE);

`ifdef FIXED_PRIO_EN
  // Lowest set index wins: scan high to low, last hit overrides.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_i[N_REQ-1-i]) begin
        win     = PTR_W'(N_REQ - 1 - i);
        win_vld = 1'b1;
      end
    end
  end
`else
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]   NREQ_X   = (PTR_W + 1)'(N_REQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   rr_idx;

  // Round-robin: first set bit at ptr+1, ptr+2, ... modulo N_REQ.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    rr_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      rr_idx = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (rr_idx >= NREQ_X) begin
        rr_idx = rr_idx - NREQ_X;
      end
      if (!win_vld && req_i[rr_idx[PTR_W-1:0]]) begin
        win     = rr_idx[PTR_W-1:0];
        win_vld = 1'b1;
      end
    end
  end
`endif

  // One-hot of the winner and its count field.
  always_comb begin
    win_oh  = '0;
    cnt_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        win_oh[i] = 1'b1;
        cnt_sel   = cnt_i[i*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      pc     <= '0;
      rem    <= '0;
      gap    <= '0;
      gnt_o  <= '0;
      done_o <= '0;
      busy_o <= 1'b0;
      led_o  <= 1'b0;
`ifndef FIXED_PRIO_EN
      ptr    <= PTR_INIT;
`endif
    end else begin
      done_o <= '0;
      // Free-running prescaler while a burst is active.
      pc <= tick ? '0 : pc + 1'b1;

      case (state)
        IDLE: begin
          pc <= '0;
          if (win_vld) begin
            gnt_o  <= win_oh;
            rem    <= cnt_sel;
            gap    <= '0;
            busy_o <= 1'b1;
`ifndef FIXED_PRIO_EN
            ptr    <= win;
`endif
            if (cnt_sel != '0) begin
              state <= ON;
              led_o <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end

        ON: begin
          if (tick) begin
            state <= OFF;
            led_o <= 1'b0;
          end
        end

        OFF: begin
          if (tick) begin
            rem <= rem - 1'b1;
            if (rem == CNT_ONE) begin
              state <= GAP;
            end else begin
              state <= ON;
              led_o <= 1'b1;
            end
          end
        end

        GAP: begin
          if (pre_tick && gap == GAP_LAST) begin
            done_o <= gnt_o;
            gnt_o  <= '0;
          end
          if (tick) begin
            if (gap == GAP_LAST) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              gap    <= '0;
            end else begin
              gap <= gap + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_sched.sv
// tb_blink_sched -- self-checking bench for blink_sched.
// Directed scenarios plus randomized bursts; expected LED/grant/done/busy
// waveforms come from the burst timing formula and a round-robin model.
module tb_blink_sched;

  localparam int DIV = 10;
  localparam int GAP = 2;
  localparam int N   = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  req_i = '0;
  logic [15:0] cnt_i = '0;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic        busy_o;
  logic        led_o;

  always #5 clk_i = ~clk_i;

  blink_sched #(
    .FREQ(100),
    .TICK_HZ(10),
    .N_REQ(4),
    .CNT_W(4),
    .GAP_TICKS(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .cnt_i(cnt_i),
    .gnt_o(gnt_o),
    .done_o(done_o),
    .busy_o(busy_o),
    .led_o(led_o)
  );

  int checks = 0;
  int errors = 0;
  int mptr   = N - 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int t, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Expected {led, gnt[3:0], done[3:0], busy} at cycle t of a burst
  // (t=0 is the first cycle with gnt high, t=L is the idle cycle after).
  function automatic logic [9:0] exp_vec(input int t, input int c, input int w);
    int         len;
    logic [3:0] oh;
    logic       led;
    len = (2 * c + GAP) * DIV;
    oh  = 4'b0001 << w;
    led = (t < 2 * c * DIV) && ((t / DIV) % 2 == 0);
    return {led, (t < len - 1) ? oh : 4'b0000, (t == len - 1) ? oh : 4'b0000, t < len};
  endfunction

  function automatic int next_winner(input logic [3:0] r, input int p);
`ifdef FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
    return 0;
  endfunction

  task automatic wait_grant(input int w, input string tag);
    int         n;
    logic [3:0] oh;
    oh = 4'b0001 << w;
    n  = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (gnt_o == 4'b0000 && n < 60);
    check({tag, " gnt"}, n, 16'(gnt_o), 16'(oh));
    check({tag, " latency"}, 0, 16'(n), 16'd1);
    mptr = w;
  endtask

  // Drive a request set at an idle cycle, then check every cycle of the
  // resulting burst plus the idle cycle after it. At cycle chg_t the
  // inputs are replaced (request withdrawal / count changes mid-burst).
  task automatic burst(input logic [3:0] r, input logic [15:0] cn, input int chg_t,
                       input logic [3:0] chg_req, input logic [15:0] chg_cnt,
                       input string tag);
    int         w;
    int         c;
    int         len;
    logic [3:0] fld;
    req_i = r;
    cnt_i = cn;
    w     = next_winner(r, mptr);
    fld   = cn[w*4 +: 4];
    c     = int'(fld);
    len   = (2 * c + GAP) * DIV;
    wait_grant(w, tag);
    for (int t = 0; t <= len; t++) begin
      if (t > 0) @(negedge clk_i);
      check(tag, t, 16'({led_o, gnt_o, done_o, busy_o}), 16'(exp_vec(t, c, w)));
      if (t == chg_t) begin
        req_i = chg_req;
        cnt_i = chg_cnt;
      end
    end
  endtask

  initial begin
    int          seen;
    int          w;
    logic [3:0]  r;
    logic [15:0] cn;

    // Reset state.
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset", 0, 16'({led_o, gnt_o, done_o, busy_o}), 16'd0);
    rst_i = 1'b0;
    mptr  = N - 1;

    // Round-robin with all requesters held, cnt=1 each.
    for (int b = 0; b < 6; b++) begin
      burst(4'hF, 16'h1111, (b == 5) ? 0 : -1, 4'h0, 16'h1111, "rr");
    end

    // Single burst of 3 flashes.
    burst(4'b0001, 16'h0003, 79, 4'h0, 16'h0003, "single");
    // Zero-count burst: gap only.
    burst(4'b0001, 16'h0000, 19, 4'h0, 16'h0000, "cnt0");
    // Withdrawal during first ON; count changed too, must be ignored.
    burst(4'b0100, 16'h0200, 5, 4'h0, 16'h0F00, "withdraw");
    // Maximum count.
    burst(4'b0010, 16'h00F0, 319, 4'h0, 16'h00F0, "cnt15");

    // Randomized bursts.
    for (int i = 0; i < 10; i++) begin
      r = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        cn[k*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      end
      burst(r, cn, $urandom_range(0, 50), 4'($urandom_range(0, 15)), 16'($urandom), "rand");
    end
    req_i = 4'h0;

    // Reset during the second ON phase aborts without done_o.
    req_i = 4'b0001;
    cnt_i = 16'h0003;
    w     = next_winner(req_i, mptr);
    wait_grant(w, "rstburst");
    req_i = 4'h0;
    for (int t = 1; t <= 22; t++) @(negedge clk_i);
    check("rst on2", 22, 16'({led_o, gnt_o, done_o, busy_o}), 16'(exp_vec(22, 3, w)));
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst abort", 0, 16'({led_o, gnt_o, done_o, busy_o}), 16'd0);
    rst_i = 1'b0;
    mptr  = N - 1;
    seen  = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (done_o != 4'b0000 || busy_o !== 1'b0) seen++;
    end
    check("no done after rst", 0, 16'(seen), 16'd0);
    burst(4'b1010, 16'h1111, 0, 4'h0, 16'h1111, "post rst");

    // Requesters 0 and 3 held.
    for (int b = 0; b < 3; b++) begin
      burst(4'b1001, 16'h1111, (b == 2) ? 0 : -1, 4'h0, 16'h1111, "prio");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
